// File: rtl/sa_ram_pkg.sv
// Shared types and helpers for the parametrised SA buffer RAM (sa_ram_rws_param).
// Words up to SA_RAM_MAX_W bits are supported by the merge helper.
package sa_ram_pkg;

    localparam int SA_RAM_BYTE_W = 8;
    localparam int SA_RAM_MAX_W  = 2048;
    localparam int SA_RAM_MAX_MW = SA_RAM_MAX_W / SA_RAM_BYTE_W;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } sa_ram_state_e;

    // Byte-wise select: mask bit i picks new_w byte i, otherwise old_w byte i.
    function automatic logic [SA_RAM_MAX_W-1:0] sa_ram_merge(
        input logic [SA_RAM_MAX_W-1:0]  old_w,
        input logic [SA_RAM_MAX_W-1:0]  new_w,
        input logic [SA_RAM_MAX_MW-1:0] mask
    );
        logic [SA_RAM_MAX_W-1:0] res;
        res = old_w;
        for (int i = 0; i < SA_RAM_MAX_MW; i++) begin
            if (mask[i]) begin
                res[i*SA_RAM_BYTE_W +: SA_RAM_BYTE_W] = new_w[i*SA_RAM_BYTE_W +: SA_RAM_BYTE_W];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sa_ram_rws_param_if.sv
// Port bundle for sa_ram_rws_param: read port, byte-masked write port, status and debug state.
interface sa_ram_rws_param_if
    import sa_ram_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int WIDTH = 512,
    parameter int AW    = $clog2(DEPTH),
    parameter int MW    = WIDTH / 8
);
    // Handshake: re/we are taken on a rising clk edge only while init_busy is 0
    // (no backpressure otherwise); dout_vld=1 marks dout as the result of a read
    // taken on the previous edge (or one edge later with the output register).
    logic [AW-1:0]    ra;
    logic             re;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic [AW-1:0]    wa;
    logic             we;
    logic [MW-1:0]    wmask;
    logic [WIDTH-1:0] di;
    logic             init_busy;
    logic [31:0]      pwrbus_ram_pd;
    sa_ram_state_e    dbg_state;

    modport master (
        output ra, re, wa, we, wmask, di, pwrbus_ram_pd,
        input  dout, dout_vld, init_busy, dbg_state
    );

    modport slave (
        input  ra, re, wa, we, wmask, di, pwrbus_ram_pd,
        output dout, dout_vld, init_busy, dbg_state
    );

endinterface

// File: rtl/sa_ram_init_ctrl.sv
// Post-reset clear sequencer: walks every address once, writing zero, then parks in READY.
module sa_ram_init_ctrl
    import sa_ram_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          init_busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output sa_ram_state_e state
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    sa_ram_state_e state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            INIT: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = READY;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READY: begin
                state_d = READY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign init_busy = busy_q;
    assign clr_we    = busy_q;
    assign clr_addr  = cnt_q;
    assign state     = state_q;

endmodule

// File: rtl/sa_ram_rws_param.sv
// Parametrised 1R/1W SA buffer RAM with byte mask, write-first forwarding and post-reset clear.
// Define SA_RAM_OUT_REG_EN to add an output register (read latency 2).
module sa_ram_rws_param
    import sa_ram_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int WIDTH = 512,
    parameter int AW    = $clog2(DEPTH),
    parameter int MW    = WIDTH / 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sa_ram_rws_param_if.slave    bus
);

    logic          init_busy;
    logic          clr_we;
    logic [AW-1:0] clr_addr;
    sa_ram_state_e init_state;

    sa_ram_init_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_init_ctrl (
        .clk       (clk),
        .rst       (rst),
        .init_busy (init_busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .state     (init_state)
    );

    logic wa_ok;
    logic ra_ok;

    // Range checks only matter when DEPTH leaves unused address codes.
    if (DEPTH == (1 << AW)) begin : g_full_range
        assign wa_ok = 1'b1;
        assign ra_ok = 1'b1;
    end else begin : g_part_range
        localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
        assign wa_ok = (bus.wa <= LAST_ADDR);
        assign ra_ok = (bus.ra <= LAST_ADDR);
    end

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [MW-1:0]    wr_mask;
    logic [WIDTH-1:0] wr_word_d;
    logic [WIDTH-1:0] rd_old;
    logic [MW-1:0]    fwd_mask;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_vld_q, dout_vld_d;

    // The clear sequencer owns the write port for the whole of INIT.
    always_comb begin
        wr_en     = clr_we | (bus.we & wa_ok);
        wr_addr   = clr_we ? clr_addr : bus.wa;
        wr_data   = clr_we ? '0 : bus.di;
        wr_mask   = clr_we ? '1 : bus.wmask;
        wr_word_d = WIDTH'(sa_ram_merge(SA_RAM_MAX_W'(mem_q[wr_addr]),
                                        SA_RAM_MAX_W'(wr_data),
                                        SA_RAM_MAX_MW'(wr_mask)));
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_word_d;
        end
    end

    // Same-address write in the same cycle overrides the masked bytes of the read.
    always_comb begin
        rd_old     = ra_ok ? mem_q[bus.ra] : '0;
        fwd_mask   = (bus.we && wa_ok && (bus.wa == bus.ra)) ? bus.wmask : '0;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;
        if (!init_busy && bus.re) begin
            dout_d     = WIDTH'(sa_ram_merge(SA_RAM_MAX_W'(rd_old),
                                             SA_RAM_MAX_W'(bus.di),
                                             SA_RAM_MAX_MW'(fwd_mask)));
            dout_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
        end
    end

`ifdef SA_RAM_OUT_REG_EN
    logic [WIDTH-1:0] dout2_q, dout2_d;
    logic             dout_vld2_q, dout_vld2_d;

    always_comb begin
        dout2_d     = dout_q;
        dout_vld2_d = dout_vld_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout2_q     <= '0;
            dout_vld2_q <= 1'b0;
        end else begin
            dout2_q     <= dout2_d;
            dout_vld2_q <= dout_vld2_d;
        end
    end

    assign bus.dout     = dout2_q;
    assign bus.dout_vld = dout_vld2_q;
`else
    assign bus.dout     = dout_q;
    assign bus.dout_vld = dout_vld_q;
`endif

    assign bus.init_busy = init_busy;
    assign bus.dbg_state = init_state;

    // The power-down bus carries no function here.
    logic unused_pwrbus;
    assign unused_pwrbus = ^bus.pwrbus_ram_pd;

endmodule
